// File: rtl/color_flag_if.sv
// color_flag_if
//   Bundles the pixel stream from the camera front end and the colour flags
//   returned to the region-overlay stage.
//   Handshake: pixel_valid qualifies R/G/B/x_pos/y_pos for exactly the cycle
//   it is high; there is no ready/backpressure, so the detector must accept
//   (or deliberately drop) every pixel. frame_start/frame_end are
//   single-cycle strobes. flags_valid is a one-cycle pulse marking a new
//   flag evaluation; the flags themselves hold between pulses.
//   master : pixel source / flag consumer (testbench or upstream pipeline)
//   slave  : color_flag_detector
interface color_flag_if;
  logic       frame_start;
  logic       frame_end;
  logic       pixel_valid;
  logic [7:0] R;
  logic [7:0] G;
  logic [7:0] B;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic       red_flag;
  logic       green_flag;
  logic       blue_flag;
  logic       yellow_flag;
  logic       flags_valid;

  modport master (
    output frame_start, frame_end, pixel_valid, R, G, B, x_pos, y_pos,
    input  red_flag, green_flag, blue_flag, yellow_flag, flags_valid
  );

  modport slave (
    input  frame_start, frame_end, pixel_valid, R, G, B, x_pos, y_pos,
    output red_flag, green_flag, blue_flag, yellow_flag, flags_valid
  );
endinterface

// File: rtl/color_flag_detector.sv
// color_flag_detector
//   Classifies each valid in-window RGB888 pixel as red/green/blue/yellow,
//   counts the classes over a frame and, at frame end, raises a one-hot flag
//   for the dominant colour (or no flag if the winner is below MIN_COUNT).
//   Ports:
//     clk         : pixel clock
//     reset       : asynchronous, active-high reset
//     bus         : color_flag_if.slave (pixel stream in, flags out)
//     o_dbg_state : current FSM state (0 IDLE, 1 ACCUM, 2 DECIDE, 3 UPDATE)
//   Optional feature macro: FLAG_HYST_EN -- flags only change after the same
//   decision has been made HYST_FRAMES times in a row.
module color_flag_detector #(
`ifdef FLAG_HYST_EN
  parameter int HYST_FRAMES = 3,
`endif
  parameter int HI_TH     = 200,
  parameter int LO_TH     = 80,
  parameter int MIN_COUNT = 4096,
  parameter int CNT_W     = 19,
  parameter int H_ACT     = 640,
  parameter int V_ACT     = 480
) (
  input  logic              clk,
  input  logic              reset,
  color_flag_if.slave       bus,
  output logic [1:0]        o_dbg_state
);

  localparam logic [7:0]       HI8   = HI_TH[7:0];
  localparam logic [7:0]       LO8   = LO_TH[7:0];
  localparam logic [9:0]       H10   = H_ACT[9:0];
  localparam logic [9:0]       V10   = V_ACT[9:0];
  localparam logic [CNT_W-1:0] MIN_C = MIN_COUNT[CNT_W-1:0];
  localparam logic [CNT_W-1:0] ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] MAX_C = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_DECIDE = 2'd2,
    S_UPDATE = 2'd3
  } state_t;

  state_t           r_state, w_next;
  logic             w_clr;
  logic             r_start_pend;
  logic [CNT_W-1:0] r_cnt_r, r_cnt_g, r_cnt_b, r_cnt_y;
  logic [CNT_W-1:0] w_best;
  logic [3:0]       w_cls;       // {yellow, blue, green, red}
  logic [3:0]       w_win;
  logic [3:0]       r_decision;
  logic [3:0]       r_flags;
  logic             r_flags_valid;
  logic             w_count_en;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == MAX_C) ? v : v + ONE_C;
  endfunction

  // Strict priority yellow > red > green > blue keeps w_cls one-hot.
  always_comb begin
    w_cls = 4'b0000;
    if (bus.R >= HI8 && bus.G >= HI8 && bus.B < LO8)      w_cls = 4'b1000;
    else if (bus.R >= HI8 && bus.G < LO8 && bus.B < LO8)  w_cls = 4'b0001;
    else if (bus.G >= HI8 && bus.R < LO8 && bus.B < LO8)  w_cls = 4'b0010;
    else if (bus.B >= HI8 && bus.R < LO8 && bus.G < LO8)  w_cls = 4'b0100;
  end

  assign w_count_en = bus.pixel_valid && (bus.x_pos < H10) && (bus.y_pos < V10) &&
                      (r_state == S_ACCUM);

  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.frame_start) begin
          w_next = S_ACCUM;
          w_clr  = 1'b1;
        end
      end
      S_ACCUM: begin
        if (bus.frame_end)        w_next = S_DECIDE;
        else if (bus.frame_start) w_clr  = 1'b1;   // aborted frame, restart counting
      end
      S_DECIDE: w_next = S_UPDATE;
      S_UPDATE: begin
        // A frame_start arriving in UPDATE itself is honoured directly.
        if (r_start_pend || bus.frame_start) begin
          w_next = S_ACCUM;
          w_clr  = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_start_pend <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_UPDATE)
        r_start_pend <= 1'b0;
      else if ((r_state == S_ACCUM && bus.frame_start && bus.frame_end) ||
               (r_state == S_DECIDE && bus.frame_start))
        r_start_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt_r <= '0;
      r_cnt_g <= '0;
      r_cnt_b <= '0;
      r_cnt_y <= '0;
    end else if (w_clr) begin
      r_cnt_r <= '0;
      r_cnt_g <= '0;
      r_cnt_b <= '0;
      r_cnt_y <= '0;
    end else if (w_count_en) begin
      if (w_cls[0]) r_cnt_r <= sat_inc(r_cnt_r);
      if (w_cls[1]) r_cnt_g <= sat_inc(r_cnt_g);
      if (w_cls[2]) r_cnt_b <= sat_inc(r_cnt_b);
      if (w_cls[3]) r_cnt_y <= sat_inc(r_cnt_y);
    end
  end

  // Only a strictly larger count displaces the current best, so ties
  // resolve red > green > blue > yellow.
  always_comb begin
    w_best = r_cnt_r;
    w_win  = 4'b0001;
    if (r_cnt_g > w_best) begin w_best = r_cnt_g; w_win = 4'b0010; end
    if (r_cnt_b > w_best) begin w_best = r_cnt_b; w_win = 4'b0100; end
    if (r_cnt_y > w_best) begin w_best = r_cnt_y; w_win = 4'b1000; end
    if (w_best < MIN_C) w_win = 4'b0000;
  end

`ifdef FLAG_HYST_EN
  localparam logic [1:0] HYST_N = HYST_FRAMES[1:0];
  logic [3:0] r_cand;
  logic [1:0] r_run;
  logic [1:0] w_run_next;

  always_comb begin
    w_run_next = 2'd1;
    if (r_decision == r_cand)
      w_run_next = (r_run == 2'd3) ? 2'd3 : r_run + 2'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_decision    <= 4'b0000;
      r_flags       <= 4'b0000;
      r_flags_valid <= 1'b0;
      r_cand        <= 4'b0000;
      r_run         <= 2'd0;
    end else begin
      r_flags_valid <= (r_state == S_UPDATE);
      if (r_state == S_DECIDE) r_decision <= w_win;
      if (r_state == S_UPDATE) begin
        r_cand <= r_decision;
        r_run  <= w_run_next;
        if (w_run_next >= HYST_N) r_flags <= r_decision;
      end
    end
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_decision    <= 4'b0000;
      r_flags       <= 4'b0000;
      r_flags_valid <= 1'b0;
    end else begin
      r_flags_valid <= (r_state == S_UPDATE);
      if (r_state == S_DECIDE) r_decision <= w_win;
      if (r_state == S_UPDATE) r_flags    <= r_decision;
    end
  end
`endif

  assign bus.red_flag    = r_flags[0];
  assign bus.green_flag  = r_flags[1];
  assign bus.blue_flag   = r_flags[2];
  assign bus.yellow_flag = r_flags[3];
  assign bus.flags_valid = r_flags_valid;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_color_flag_detector.sv
module tb_color_flag_detector;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;
  int         cyc = 0;
  int         n_pass = 0;
  int         n_total = 0;
  logic [3:0] exp_q[$];
  int         cyc_q[$];

  localparam logic [3:0] F_NONE = 4'b0000;
  localparam logic [3:0] F_R    = 4'b0001;
  localparam logic [3:0] F_G    = 4'b0010;
  localparam logic [3:0] F_B    = 4'b0100;
  localparam logic [3:0] F_Y    = 4'b1000;

  color_flag_if bus();

  color_flag_detector #(.MIN_COUNT(16), .CNT_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] flags_now();
    return {bus.yellow_flag, bus.blue_flag, bus.green_flag, bus.red_flag};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- driver tasks ----------------
  task automatic clr_inputs();
    bus.frame_start = 1'b0;
    bus.frame_end   = 1'b0;
    bus.pixel_valid = 1'b0;
    bus.R = 8'd0; bus.G = 8'd0; bus.B = 8'd0;
    bus.x_pos = 10'd0; bus.y_pos = 10'd0;
  endtask

  task automatic gap(input int n);
    repeat (n) begin @(negedge clk); clr_inputs(); end
  endtask

  task automatic px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                    input logic [9:0] x, input logic [9:0] y);
    @(negedge clk);
    clr_inputs();
    bus.pixel_valid = 1'b1;
    bus.R = r; bus.G = g; bus.B = b;
    bus.x_pos = x; bus.y_pos = y;
  endtask

  task automatic burst(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input int n);
    for (int i = 0; i < n; i++) px(r, g, b, 10'(i), 10'(i % 7));
  endtask

  task automatic fs();
    @(negedge clk); clr_inputs(); bus.frame_start = 1'b1;
  endtask

  // Flags are due after the third rising edge from the one sampling frame_end.
  task automatic fe(input logic [3:0] e);
    @(negedge clk); clr_inputs(); bus.frame_end = 1'b1;
    exp_q.push_back(e); cyc_q.push_back(cyc + 3);
  endtask

  task automatic fsfe(input logic [3:0] e);
    @(negedge clk); clr_inputs(); bus.frame_end = 1'b1; bus.frame_start = 1'b1;
    exp_q.push_back(e); cyc_q.push_back(cyc + 3);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin @(negedge clk); n++; end
    chk("queue_drained", exp_q.size(), 0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset && bus.flags_valid) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_flags_valid: got flags %b expected no pulse (cycle %0d)",
                 flags_now(), cyc);
      end else begin
        logic [3:0] e;
        int         ec;
        e  = exp_q.pop_front();
        ec = cyc_q.pop_front();
        chk("flags", int'(flags_now()), int'(e));
        chk("latency_cycle", cyc, ec);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    clr_inputs();
    repeat (3) @(negedge clk);
    chk("reset_flags", int'(flags_now()), 0);
    chk("reset_flags_valid", int'(bus.flags_valid), 0);
    chk("reset_state", int'(dbg_state), 0);
    reset = 1'b0;
    gap(2);

`ifdef FLAG_HYST_EN
    // Same decision three times before the flag moves.
    for (int f = 0; f < 3; f++) begin
      fs(); burst(8'h10, 8'hFF, 8'h10, 20);
      fe((f == 2) ? F_G : F_NONE); gap(4);
    end
    // A single red decision must not displace green.
    fs(); burst(8'hFF, 8'h10, 8'h10, 20); fe(F_G); gap(4);
    drain();
    fs(); burst(8'h10, 8'hFF, 8'h10, 8);
    @(negedge clk); #2 reset = 1'b1;
    #1 chk("async_reset_flags", int'(flags_now()), 0);
    @(negedge clk); reset = 1'b0;
`else
    // 20 red + 100 grey
    fs(); burst(8'hFF, 8'h10, 8'h10, 20); burst(8'h80, 8'h80, 8'h80, 100);
    fe(F_R); gap(4);
    // 15 green: one short of MIN_COUNT
    fs(); burst(8'h10, 8'hFF, 8'h10, 15); fe(F_NONE); gap(4);
    // blue/yellow tie -> blue, then yellow by one
    fs(); burst(8'h10, 8'h10, 8'hFF, 30); burst(8'hFF, 8'hFF, 8'h10, 30); fe(F_B); gap(4);
    fs(); burst(8'hFF, 8'hFF, 8'h10, 31); burst(8'h10, 8'h10, 8'hFF, 30); fe(F_Y); gap(4);
    // out-of-window red pixels
    fs();
    for (int i = 0; i < 10; i++) px(8'hFF, 8'h10, 8'h10, 10'd700, 10'(i));
    for (int i = 0; i < 10; i++) px(8'hFF, 8'h10, 8'h10, 10'(i), 10'd500);
    fe(F_NONE); gap(4);
    // coincident frame_start/frame_end, next frame without a new frame_start
    fs(); burst(8'hFF, 8'h10, 8'h10, 20); fsfe(F_R); gap(3);
    burst(8'h10, 8'hFF, 8'h10, 20); fe(F_G); gap(4);
    // aborted frame: 20 blue discarded, 17 red wins
    fs(); burst(8'h10, 8'h10, 8'hFF, 20); fs(); burst(8'hFF, 8'h10, 8'h10, 17);
    fe(F_R); gap(4);
    // saturation at 31: red 36 and yellow 33 both clamp, tie -> red
    fs(); burst(8'hFF, 8'h10, 8'h10, 36); burst(8'hFF, 8'hFF, 8'h10, 33);
    fe(F_R); gap(4);
    // frame_end in IDLE is ignored
    @(negedge clk); clr_inputs(); bus.frame_end = 1'b1;
    gap(5);
    chk("idle_fe_flags_hold", int'(flags_now()), int'(F_R));
    chk("idle_fe_state", int'(dbg_state), 0);
    // exactly MIN_COUNT green
    fs(); burst(8'h10, 8'hFF, 8'h10, 16); fe(F_G); gap(4);
    drain();
    // async reset mid-frame
    fs(); burst(8'hFF, 8'h10, 8'h10, 10);
    @(negedge clk); #2 reset = 1'b1;
    #1 chk("async_reset_flags", int'(flags_now()), 0);
    chk("async_reset_state", int'(dbg_state), 0);
    @(negedge clk); clr_inputs(); reset = 1'b0;
    gap(2);
    fs(); burst(8'hFF, 8'h10, 8'h10, 16); fe(F_R); gap(4);
`endif
    drain();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
